// File: rtl/game_countdown_timer.sv
// Round countdown timer: counts START_SECONDS down in BCD after a start request.
// Optional `warn` output is built when the TIMER_WARN_EN macro is defined.
module game_countdown_timer #(
  parameter int TICK_DIV      = 100_000_000,
  parameter int START_SECONDS = 60,
  parameter int WARN_SECONDS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       running,
  output logic       timerEnd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
`ifdef TIMER_WARN_EN
  ,
  output logic       warn
`endif
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    RELOAD  = {4'(START_SECONDS / 10), 4'(START_SECONDS % 10)};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // BCD decrement that saturates at 00 instead of wrapping.
  function automatic logic [7:0] bcd_dec_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00)
      r = 8'h00;
    else if (v[3:0] == 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  logic [1:0]    state_p0, state_nx;
  logic [PW-1:0] presc_p0, presc_nx;
  logic [7:0]    digits_p0, digits_nx;
  logic          tick;

  assign tick = (presc_p0 == PS_LAST);

  always_comb begin
    state_nx  = state_p0;
    presc_nx  = presc_p0;
    digits_nx = digits_p0;
    case (state_p0)
      IDLE: begin
        digits_nx = RELOAD;
        if (start) begin
          state_nx = RUN;
          presc_nx = '0;
        end
      end
      RUN: begin
        // start is deliberately ignored here so a held button cannot restart the round
        if (tick) begin
          presc_nx  = '0;
          digits_nx = bcd_dec_sat(digits_p0);
          if (digits_nx == 8'h00)
            state_nx = DONE;
        end else begin
          presc_nx = presc_p0 + PW'(1);
        end
      end
      DONE: begin
        digits_nx = 8'h00;
        if (start) begin
          state_nx  = RUN;
          presc_nx  = '0;
          digits_nx = RELOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: state, prescaler, digits and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p0  <= IDLE;
      presc_p0  <= '0;
      digits_p0 <= RELOAD;
      running   <= 1'b0;
      timerEnd  <= 1'b0;
    end else begin
      state_p0  <= state_nx;
      presc_p0  <= presc_nx;
      digits_p0 <= digits_nx;
      running   <= (state_nx == RUN);
      timerEnd  <= (state_nx == DONE);
    end
  end

  assign sec_tens = digits_p0[7:4];
  assign sec_ones = digits_p0[3:0];

`ifdef TIMER_WARN_EN
  // Packed BCD compares correctly as an unsigned byte.
  localparam logic [7:0] WARN_BCD = {4'(WARN_SECONDS / 10), 4'(WARN_SECONDS % 10)};

  always_ff @(posedge clk) begin
    if (!rst)
      warn <= 1'b0;
    else
      warn <= (state_nx == RUN) && (digits_nx <= WARN_BCD) && (digits_nx != 8'h00);
  end
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// Self-checking bench for game_countdown_timer: vector table, corner sequences,
// and randomized start/reset traffic against a time-based reference model.
module tb_game_countdown_timer;

  localparam int T = 4;
  localparam int S = 3;
  localparam int W = 2;
  localparam int S11 = 11;
`ifdef TIMER_WARN_EN
  localparam bit HAS_WARN = 1'b1;
`else
  localparam bit HAS_WARN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start11 = 1'b0;
  logic running, timerEnd, warn;
  logic [3:0] sec_tens, sec_ones;
  logic running11, timerEnd11, warn11;
  logic [3:0] tens11, ones11;

`ifndef TIMER_WARN_EN
  assign warn   = 1'b0;
  assign warn11 = 1'b0;
`endif

  game_countdown_timer #(.TICK_DIV(T), .START_SECONDS(S), .WARN_SECONDS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .running(running), .timerEnd(timerEnd),
    .sec_tens(sec_tens), .sec_ones(sec_ones)
`ifdef TIMER_WARN_EN
    , .warn(warn)
`endif
  );

  game_countdown_timer #(.TICK_DIV(T), .START_SECONDS(S11), .WARN_SECONDS(W)) dut11 (
    .clk(clk), .rst(rst), .start(start11), .running(running11), .timerEnd(timerEnd11),
    .sec_tens(tens11), .sec_ones(ones11)
`ifdef TIMER_WARN_EN
    , .warn(warn11)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 running, 2 expired; remaining time from start edge.
  int cyc    = 0;
  int m_mode = 0;
  int m_t0   = 0;
  int m_rem  = 0;

  typedef struct {
    logic r;
    logic s;
    logic run;
    logic en;
    logic w;
    int   v;
  } vec_t;
  vec_t vq[$];

  function automatic logic [11:0] pk(input logic r, input logic e, input logic w, input int v);
    return {1'b0, r, e, w, 4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] dut_pk();
    return {1'b0, running, timerEnd, warn, sec_tens, sec_ones};
  endfunction

  function automatic logic [11:0] dut11_pk();
    return {1'b0, running11, timerEnd11, warn11, tens11, ones11};
  endfunction

  function automatic logic [11:0] model_exp();
    logic [11:0] e;
    if (m_mode == 1)
      e = pk(1'b1, 1'b0, HAS_WARN && (m_rem <= W), m_rem);
    else if (m_mode == 2)
      e = pk(1'b0, 1'b1, 1'b0, 0);
    else
      e = pk(1'b0, 1'b0, 1'b0, S);
    return e;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h, required %03h ({0,running,timerEnd,warn,tens,ones})",
               name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s);
    rst   = r;
    start = s;
    @(posedge clk);
    #1;
    cyc++;
    if (!r)
      m_mode = 0;
    else if (m_mode != 1 && s) begin
      m_mode = 1;
      m_t0   = cyc;
    end
    if (m_mode == 1) begin
      m_rem = S - (cyc - m_t0) / T;
      if (m_rem <= 0) m_mode = 2;
    end
    check($sformatf("model_cyc%0d", cyc), dut_pk(), model_exp());
  endtask

  task automatic add(input logic r, input logic s, input logic run, input logic en,
                     input logic w, input int v, input int reps);
    vec_t x;
    x = '{r: r, s: s, run: run, en: en, w: w, v: v};
    for (int k = 0; k < reps; k++) vq.push_back(x);
  endtask

  initial begin
    // Reset, then one normal round with a single-cycle start.
    add(0, 0, 0, 0, 0, 3, 3);
    add(1, 1, 1, 0, 0, 3, 1);
    add(1, 0, 1, 0, 0, 3, 3);
    add(1, 0, 1, 0, 1, 2, 4);
    add(1, 0, 1, 0, 1, 1, 4);
    add(1, 0, 0, 1, 0, 0, 2);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].s);
      check($sformatf("vec%0d", i), dut_pk(),
            pk(vq[i].run, vq[i].en, vq[i].w & HAS_WARN, vq[i].v));
    end

    // Held start: one round, then restart one cycle after expiry.
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1);
      if (i == 5)  check("held_no_restart", dut_pk(), pk(1, 0, HAS_WARN, 2));
      if (i == 11) check("held_e11", dut_pk(), pk(1, 0, HAS_WARN, 1));
      if (i == 12) check("held_expire", dut_pk(), pk(0, 1, 0, 0));
      if (i == 13) check("held_restart", dut_pk(), pk(1, 0, 0, 3));
    end
    step(1, 0);

    // Reset mid-round with a simultaneous start.
    step(0, 0);
    step(1, 1);
    for (int i = 1; i < 6; i++) step(1, 0);
    step(0, 1);
    check("midreset_idle", dut_pk(), pk(0, 0, 0, 3));
    step(1, 0);
    check("midreset_start_ignored", dut_pk(), pk(0, 0, 0, 3));

    // BCD borrow on the 11-second instance.
    start11 = 1'b1;
    step(1, 0);
    start11 = 1'b0;
    check("bcd11_start", dut11_pk(), pk(1, 0, 0, 11));
    for (int c = 1; c <= 4 * S11; c++) begin
      int v;
      step(1, 0);
      v = S11 - c / T;
      if (c % T == 0 || c % T == 2)
        check($sformatf("bcd11_c%0d", c), dut11_pk(),
              pk(v != 0, v == 0, HAS_WARN && v <= W && v > 0, v));
    end
    check("bcd11_hold00", dut11_pk(), pk(0, 1, 0, 0));

    // Randomized start/reset traffic against the model.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 149) != 0, $urandom_range(0, 99) < 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
